// File: rtl/pc_sequencer.sv
// Purpose : 12-bit program counter sequencer with branch/jump/call/return redirection and a 4-entry return-address stack.
// Latency : a redirect target reaches pc one cycle after the request; pc_valid reasserts one cycle after that.
// Backpres: stall freezes pc, RAS and FSM state in RUN; pc_sel is still driven combinationally.
//
// Ports:
//   clk, reset           - clock and synchronous active-high reset
//   stall                - hold all state this cycle (RUN only)
//   is_branch/branch_taken/branch_target - conditional branch and its destination
//   is_jump/is_call/jump_target          - unconditional jump / call and shared destination
//   is_ret               - return to top of RAS
//   pc, pc_valid, flush  - registered PC, fetch-valid, one-cycle post-redirect flush
//   pc_sel               - combinational next-PC mux select (00 +1, 01 branch, 10 jump, 11 RAS)
//   ras_overflow/ras_underflow - registered one-cycle error pulses
module pc_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        is_branch,
    input  logic        branch_taken,
    input  logic [11:0] branch_target,
    input  logic        is_jump,
    input  logic        is_call,
    input  logic [11:0] jump_target,
    input  logic        is_ret,
    output logic [11:0] pc,
    output logic        pc_valid,
    output logic [1:0]  pc_sel,
    output logic        flush,
    output logic        ras_overflow,
    output logic        ras_underflow
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_REDIR = 2'd2
    } state_t;

    localparam logic [1:0] SEL_INC = 2'b00;
    localparam logic [1:0] SEL_BR  = 2'b01;
    localparam logic [1:0] SEL_JMP = 2'b10;
    localparam logic [1:0] SEL_RAS = 2'b11;

    state_t      state_q, state_d;
    logic [11:0] pc_q, pc_d;
    logic        pc_valid_q, pc_valid_d;
    logic        flush_q, flush_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;

    // RAS is a circular buffer: ptr points at the next write slot, so the
    // top entry is at ptr-1. When full, ptr also points at the oldest entry,
    // which makes a push-on-full overwrite the oldest for free.
    logic [11:0] ras_q [4];
    logic [11:0] ras_d [4];
    logic [1:0]  ptr_q, ptr_d;
    logic [2:0]  cnt_q, cnt_d;

    logic [11:0] pc_inc;
    logic [11:0] ras_top;
    logic [1:0]  sel;

    assign pc_inc  = pc_q + 12'd1;
    assign ras_top = ras_q[ptr_q - 2'd1];

    // Next-PC select. Only RUN makes decisions; a return dominates everything
    // else even when the RAS is empty (it then falls back to sequential).
    always_comb begin
        sel = SEL_INC;
        if (state_q == ST_RUN) begin
            if (is_ret) begin
                sel = (cnt_q != 3'd0) ? SEL_RAS : SEL_INC;
            end else if (is_jump || is_call) begin
                sel = SEL_JMP;
            end else if (is_branch && branch_taken) begin
                sel = SEL_BR;
            end
        end
    end

    assign pc_sel = sel;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ras_d[i] = ras_q[i];
        end

        unique case (state_q)
            ST_BOOT: begin
                // pc stays at 0 so the first valid fetch is address 0
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!stall) begin
                    unique case (sel)
                        SEL_INC: pc_d = pc_inc;
                        SEL_BR:  pc_d = branch_target;
                        SEL_JMP: pc_d = jump_target;
                        SEL_RAS: pc_d = ras_top;
                    endcase
                    if (sel != SEL_INC) begin
                        state_d = ST_REDIR;
                    end

                    if (is_ret) begin
                        if (cnt_q != 3'd0) begin
                            ptr_d = ptr_q - 2'd1;
                            cnt_d = cnt_q - 3'd1;
                        end else begin
                            unf_d = 1'b1;
                        end
                    end else if (is_call) begin
                        ras_d[ptr_q] = pc_inc;
                        ptr_d        = ptr_q + 2'd1;
                        if (cnt_q == 3'd4) begin
                            ovf_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
            end
            ST_REDIR: begin
                // target was presented during REDIR; resume fetch after it
                pc_d    = pc_inc;
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_BOOT;
                pc_d    = 12'h000;
            end
        endcase

        pc_valid_d = (state_d == ST_RUN);
        flush_d    = (state_d == ST_REDIR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_BOOT;
            pc_q       <= 12'h000;
            pc_valid_q <= 1'b0;
            flush_q    <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            ptr_q      <= 2'd0;
            cnt_q      <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                ras_q[i] <= 12'h000;
            end
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            flush_q    <= flush_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            for (int i = 0; i < 4; i++) begin
                ras_q[i] <= ras_d[i];
            end
        end
    end

    assign pc            = pc_q;
    assign pc_valid      = pc_valid_q;
    assign flush         = flush_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Purpose : self-checking bench for pc_sequencer using a behavioural model and an expected-output queue.
// Latency : each driven cycle pushes the expected registered outputs; they are popped one edge later.
// Backpres: stall cycles are modelled like any other input.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, is_branch, branch_taken, is_jump, is_call, is_ret;
    logic [11:0] branch_target, jump_target;
    logic [11:0] pc;
    logic        pc_valid, flush, ras_overflow, ras_underflow;
    logic [1:0]  pc_sel;

    int n_checks = 0;
    int n_fails  = 0;

    // model state: 0 = boot, 1 = run, 2 = redirect
    int          m_state;
    logic [11:0] m_pc;
    logic [11:0] m_ras [$];
    logic [15:0] sb [$];

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .is_branch     (is_branch),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .is_jump       (is_jump),
        .is_call       (is_call),
        .jump_target   (jump_target),
        .is_ret        (is_ret),
        .pc            (pc),
        .pc_valid      (pc_valid),
        .pc_sel        (pc_sel),
        .flush         (flush),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        stall = 1'b0; is_branch = 1'b0; branch_taken = 1'b0; is_jump = 1'b0;
        is_call = 1'b0; is_ret = 1'b0; branch_target = '0; jump_target = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        m_state = 0; m_pc = 12'h000; m_ras.delete(); sb.delete();
        check("rst_pc",    {20'd0, pc}, 32'h0);
        check("rst_valid", {31'd0, pc_valid}, 32'h0);
        check("rst_flush", {31'd0, flush}, 32'h0);
        check("rst_err",   {30'd0, ras_overflow, ras_underflow}, 32'h0);
    endtask

    // One clock of stimulus: check pc_sel now, advance the model, queue the
    // expected registered outputs and compare them after the edge.
    task automatic cyc(input logic st, input logic br, input logic tk, input logic [11:0] bt,
                       input logic jmp, input logic cal, input logic ret, input logic [11:0] jt);
        logic [1:0]  e_sel;
        logic        e_ovf, e_unf;
        logic [11:0] ret_addr;
        logic [15:0] exp_v, got_v;
        stall = st; is_branch = br; branch_taken = tk; branch_target = bt;
        is_jump = jmp; is_call = cal; is_ret = ret; jump_target = jt;
        #1;
        e_sel = 2'b00;
        if (m_state == 1) begin
            if (ret)            e_sel = (m_ras.size() > 0) ? 2'b11 : 2'b00;
            else if (jmp | cal) e_sel = 2'b10;
            else if (br & tk)   e_sel = 2'b01;
        end
        check("pc_sel", {30'd0, pc_sel}, {30'd0, e_sel});

        e_ovf = 1'b0; e_unf = 1'b0;
        ret_addr = m_pc + 12'd1;
        if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 2) begin
            m_pc = m_pc + 12'd1;
            m_state = 1;
        end else if (!st) begin
            if (ret) begin
                if (m_ras.size() > 0) begin
                    m_pc = m_ras.pop_back();
                    m_state = 2;
                end else begin
                    e_unf = 1'b1;
                    m_pc = ret_addr;
                end
            end else begin
                if (cal) begin
                    if (m_ras.size() == 4) begin
                        void'(m_ras.pop_front());
                        e_ovf = 1'b1;
                    end
                    m_ras.push_back(ret_addr);
                end
                if (jmp | cal)    begin m_pc = jt; m_state = 2; end
                else if (br & tk) begin m_pc = bt; m_state = 2; end
                else              m_pc = ret_addr;
            end
        end
        sb.push_back({m_pc, (m_state == 1), (m_state == 2), e_ovf, e_unf});

        @(posedge clk); #1;
        got_v = {pc, pc_valid, flush, ras_overflow, ras_underflow};
        exp_v = sb.pop_front();
        check("outs{pc,vld,fl,ovf,unf}", {16'd0, got_v}, {16'd0, exp_v});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 12'h0, 0, 0, 0, 12'h0);
    endtask

    task automatic call_to(input logic [11:0] t);
        cyc(0, 0, 0, 12'h0, 0, 1, 0, t);
    endtask

    task automatic ret_op();
        cyc(0, 0, 0, 12'h0, 0, 0, 1, 12'h0);
    endtask

    initial begin
        // Sequential fetch after reset, then a taken branch at 0x010
        do_reset();
        idle(17);
        check("seq_pc10", {20'd0, pc}, 32'h010);
        cyc(0, 1, 1, 12'h200, 0, 0, 0, 12'h0);
        check("br_pc",    {20'd0, pc}, 32'h200);
        check("br_flush", {31'd0, flush}, 32'h1);
        idle(1);
        check("br_next",  {20'd0, pc}, 32'h201);
        check("br_valid", {31'd0, pc_valid}, 32'h1);
        idle(2);

        // Call at 0x005 then return to 0x006
        do_reset();
        idle(6);
        call_to(12'h100);
        idle(3);
        ret_op();
        check("ret_pc", {20'd0, pc}, 32'h006);
        idle(2);

        // Five calls, four good returns, one underflowing return
        do_reset();
        idle(3);
        for (int k = 0; k < 5; k++) begin
            call_to(12'h300 + 12'(k * 16));
            idle(2);
        end
        for (int k = 0; k < 4; k++) begin
            ret_op();
            idle(1);
        end
        ret_op();
        check("unf_pulse", {31'd0, ras_underflow}, 32'h1);
        idle(1);

        // Return + call + taken branch together: return wins, no push
        do_reset();
        idle(2);
        call_to(12'h040);
        idle(1);
        cyc(0, 1, 1, 12'h7A0, 0, 1, 1, 12'h050);
        idle(2);
        ret_op();
        idle(1);

        // Modulo wrap at 0xFFF, then a 3-cycle stall with a pending branch
        do_reset();
        idle(1);
        cyc(0, 0, 0, 12'h0, 1, 0, 0, 12'hFFE);
        idle(2);
        check("wrap_pc", {20'd0, pc}, 32'h000);
        for (int k = 0; k < 3; k++) cyc(1, 1, 1, 12'h123, 0, 0, 0, 12'h0);
        check("stall_pc", {20'd0, pc}, 32'h000);
        idle(2);

        // Reset in the middle of a redirect
        cyc(0, 1, 1, 12'h555, 0, 0, 0, 12'h0);
        do_reset();
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Hard bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
